// File: rtl/ctrl_pipe_pkg.sv
// Shared constants for the control-signal pipeline: stage indices, bundle
// field positions and the default bundle width.
package ctrl_pipe_pkg;

  localparam int CTRL_W  = 8;
  localparam int NUM_STG = 3;

  localparam int STG_E = 0;
  localparam int STG_M = 1;
  localparam int STG_W = 2;

  localparam int F_MEMTOREG = 0;
  localparam int F_MEMWRITE = 1;
  localparam int F_ALUSRC   = 2;
  localparam int F_REGDST   = 3;
  localparam int F_REGWRITE = 4;
  localparam int F_ALUCTRL  = 5;  // alucontrol[2:0] occupies bits 7:5
  // The multi-cycle flag aliases alucontrol[2]: that opcode class is mul/div.
  localparam int F_MC       = 7;

endpackage

// File: rtl/ctrl_pipe_if.sv
// Decode-side and datapath-side signals of the control pipeline.
interface ctrl_pipe_if
  import ctrl_pipe_pkg::*;
#(
  parameter int W = CTRL_W,
  parameter int N = NUM_STG
) ();

  logic [W-1:0]   ctrl_d;
  logic           valid_d;
  logic [N-1:0]   stall_i;
  logic [N-1:0]   flush_i;
  logic [N*W-1:0] ctrl_q;
  logic [N-1:0]   valid_q;
  logic           stall_d_o;
  logic           mc_busy_o;

  modport master (
    output ctrl_d, valid_d, stall_i, flush_i,
    input  ctrl_q, valid_q, stall_d_o, mc_busy_o
  );

  modport slave (
    input  ctrl_d, valid_d, stall_i, flush_i,
    output ctrl_q, valid_q, stall_d_o, mc_busy_o
  );

endinterface

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage: control bundle plus valid bit, with priority
// flush > hold > bubble > load.
module ctrl_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         hold,
  input  logic         bubble,
  input  logic [W-1:0] ctrlIn,
  input  logic         validIn,
  output logic [W-1:0] ctrlOut,
  output logic         validOut
);

  // NOTE: state registers use non-blocking assignments and clear on the
  // asynchronous reset edge, so they are never X after rst goes low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrlOut  <= '0;
      validOut <= 1'b0;
    end else if (flush || (bubble && !hold)) begin
      ctrlOut  <= '0;
      validOut <= 1'b0;
    end else if (!hold) begin
      ctrlOut  <= ctrlIn;
      validOut <= validIn;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Control-signal pipeline: N registered stages with stall/flush, bubble
// insertion behind held stages and a multi-cycle hold in stage E.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int W      = CTRL_W,
  parameter int N      = NUM_STG,
  parameter int MC_BIT = 7,
  parameter int MC_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  ctrl_pipe_if.slave  bus
);

  localparam int CNT_W = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;

  logic [W-1:0]     stageQ [N];
  logic [N-1:0]     stageV;
  logic [N-1:0]     hold;
  logic [N-1:0]     bubble;
  logic [CNT_W-1:0] cnt;
  logic             mcBusy;
  logic             mcLoad;

  assign mcBusy = stageV[STG_E] & stageQ[STG_E][MC_BIT] & (cnt != '0);
  assign mcLoad = !hold[STG_E] & bus.valid_d & bus.ctrl_d[MC_BIT];

  // NOTE: every combinational output gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    hold = '0;
    for (int k = 0; k < N; k++)
      for (int j = k; j < N; j++)
        if (bus.stall_i[j]) hold[k] = 1'b1;
    if (mcBusy) hold[STG_E] = 1'b1;
  end

  always_comb begin
    bubble = '0;
    for (int k = 1; k < N; k++) bubble[k] = hold[k-1];
  end

  // Counter keeps running under external stall so the op's latency is fixed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     cnt <= '0;
    else if (bus.flush_i[STG_E])  cnt <= '0;
    else if (mcLoad)              cnt <= CNT_W'(MC_LAT - 1);
    else if (cnt != '0)           cnt <= cnt - CNT_W'(1);
  end

  for (genvar k = 0; k < N; k++) begin : g_stage
    logic [W-1:0] upCtrl;
    logic         upValid;

    if (k == 0) begin : g_src_decode
      assign upCtrl  = bus.ctrl_d;
      assign upValid = bus.valid_d;
    end else begin : g_src_stage
      assign upCtrl  = stageQ[k-1];
      assign upValid = stageV[k-1];
    end

    ctrl_stage_reg #(.W(W)) u_reg (
      .clk      (clk),
      .rst      (rst),
      .flush    (bus.flush_i[k]),
      .hold     (hold[k]),
      .bubble   (bubble[k]),
      .ctrlIn   (upCtrl),
      .validIn  (upValid),
      .ctrlOut  (stageQ[k]),
      .validOut (stageV[k])
    );

    assign bus.ctrl_q[k*W +: W] = stageQ[k];
  end

  assign bus.valid_q   = stageV;
  assign bus.stall_d_o = hold[STG_E];
  assign bus.mc_busy_o = mcBusy;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: a per-cycle vector table followed by
// hand-written multi-cycle, flush and reset sequences.
module tb_ctrl_pipe;

  localparam int W = 8;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   busyCount;

  always #5 clk = ~clk;

  ctrl_pipe_if #(.W(W), .N(N)) bus ();

  ctrl_pipe #(.W(W), .N(N), .MC_BIT(7), .MC_LAT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic         vd;
    logic [7:0]   cd;
    logic [2:0]   st;
    logic [2:0]   fl;
    logic         expSd;   // stall_d_o before the edge
    logic         expMb;   // mc_busy_o before the edge
    logic [23:0]  expQ;    // {stage2, stage1, stage0} after the edge
    logic [2:0]   expV;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vd, input logic [7:0] cd, input logic [2:0] st, input logic [2:0] fl);
    bus.valid_d = vd;
    bus.ctrl_d  = cd;
    bus.stall_i = st;
    bus.flush_i = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // straight flow
    vecs[0]  = '{1'b1, 8'h15, 3'b000, 3'b000, 1'b0, 1'b0, 24'h00_00_15, 3'b001};
    vecs[1]  = '{1'b0, 8'h00, 3'b000, 3'b000, 1'b0, 1'b0, 24'h00_15_00, 3'b010};
    vecs[2]  = '{1'b0, 8'h00, 3'b000, 3'b000, 1'b0, 1'b0, 24'h15_00_00, 3'b100};
    // fill C/B/A, then stall stage 1 for two cycles
    vecs[3]  = '{1'b1, 8'h0C, 3'b000, 3'b000, 1'b0, 1'b0, 24'h00_00_0C, 3'b001};
    vecs[4]  = '{1'b1, 8'h0B, 3'b000, 3'b000, 1'b0, 1'b0, 24'h00_0C_0B, 3'b011};
    vecs[5]  = '{1'b1, 8'h0A, 3'b000, 3'b000, 1'b0, 1'b0, 24'h0C_0B_0A, 3'b111};
    vecs[6]  = '{1'b1, 8'h0D, 3'b010, 3'b000, 1'b1, 1'b0, 24'h00_0B_0A, 3'b011};
    vecs[7]  = '{1'b1, 8'h0D, 3'b010, 3'b000, 1'b1, 1'b0, 24'h00_0B_0A, 3'b011};
    vecs[8]  = '{1'b1, 8'h0D, 3'b000, 3'b000, 1'b0, 1'b0, 24'h0B_0A_0D, 3'b111};
    // flush beats stall on stage 0
    vecs[9]  = '{1'b1, 8'h0E, 3'b001, 3'b001, 1'b1, 1'b0, 24'h0A_00_00, 3'b100};
    // flush stage 2 while stage 1 held, then flush+stall stage 1
    vecs[10] = '{1'b1, 8'h21, 3'b000, 3'b000, 1'b0, 1'b0, 24'h00_00_21, 3'b001};
    vecs[11] = '{1'b1, 8'h22, 3'b000, 3'b000, 1'b0, 1'b0, 24'h00_21_22, 3'b011};
    vecs[12] = '{1'b1, 8'h23, 3'b010, 3'b100, 1'b1, 1'b0, 24'h00_21_22, 3'b011};
    vecs[13] = '{1'b1, 8'h23, 3'b010, 3'b010, 1'b1, 1'b0, 24'h00_00_22, 3'b001};
    vecs[14] = '{1'b0, 8'h00, 3'b000, 3'b000, 1'b0, 1'b0, 24'h00_22_00, 3'b010};

    drive(1'b0, 8'h00, 3'b000, 3'b000);
    #2;
    check("reset ctrl_q",  32'(bus.ctrl_q), 32'h0);
    check("reset valid_q", 32'(bus.valid_q), 32'h0);
    check("reset stall_d", 32'(bus.stall_d_o), 32'h0);
    check("reset mc_busy", 32'(bus.mc_busy_o), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(vecs[i].vd, vecs[i].cd, vecs[i].st, vecs[i].fl);
      #1;
      check($sformatf("vec%0d stall_d", i), 32'(bus.stall_d_o), 32'(vecs[i].expSd));
      check($sformatf("vec%0d mc_busy", i), 32'(bus.mc_busy_o), 32'(vecs[i].expMb));
      step();
      check($sformatf("vec%0d ctrl_q", i),  32'(bus.ctrl_q),  32'(vecs[i].expQ));
      check($sformatf("vec%0d valid_q", i), 32'(bus.valid_q), 32'(vecs[i].expV));
    end

    // multi-cycle op: stage 0 holds 80 for 4 cycles, busy for 3
    @(negedge clk);
    drive(1'b1, 8'h80, 3'b000, 3'b000);
    step();
    drive(1'b1, 8'h01, 3'b000, 3'b000);
    busyCount = 0;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("mc hold%0d stage0", c), 32'(bus.ctrl_q[7:0]), 32'h80);
      check($sformatf("mc hold%0d valid0", c), 32'(bus.valid_q[0]), 32'h1);
      check($sformatf("mc hold%0d stall_d", c), 32'(bus.stall_d_o), (c < 4) ? 32'h1 : 32'h0);
      if (c > 1) begin
        check($sformatf("mc bubble%0d stage1", c), 32'(bus.ctrl_q[15:8]), 32'h0);
        check($sformatf("mc bubble%0d valid1", c), 32'(bus.valid_q[1]), 32'h0);
      end
      if (bus.mc_busy_o) busyCount++;
      step();
    end
    check("mc busy cycles", 32'(busyCount), 32'd3);
    check("mc advance stage0", 32'(bus.ctrl_q[7:0]), 32'h01);
    check("mc advance stage1", 32'(bus.ctrl_q[15:8]), 32'h80);
    check("mc advance valid1", 32'(bus.valid_q[1]), 32'h1);
    check("mc advance busy", 32'(bus.mc_busy_o), 32'h0);

    // multi-cycle op flushed after one busy cycle
    @(negedge clk);
    drive(1'b1, 8'h80, 3'b000, 3'b000);
    step();
    check("mcf busy before flush", 32'(bus.mc_busy_o), 32'h1);
    @(negedge clk);
    drive(1'b1, 8'h02, 3'b000, 3'b001);
    step();
    check("mcf stage0 cleared", 32'(bus.ctrl_q[7:0]), 32'h0);
    check("mcf valid0 cleared", 32'(bus.valid_q[0]), 32'h0);
    check("mcf busy cleared", 32'(bus.mc_busy_o), 32'h0);
    check("mcf stall_d cleared", 32'(bus.stall_d_o), 32'h0);
    @(negedge clk);
    drive(1'b1, 8'h02, 3'b000, 3'b000);
    step();
    check("mcf next load", 32'(bus.ctrl_q[7:0]), 32'h02);
    check("mcf next valid", 32'(bus.valid_q[0]), 32'h1);

    // reset asserted mid multi-cycle hold with all stages valid
    @(negedge clk);
    drive(1'b1, 8'h03, 3'b000, 3'b000);
    step();
    drive(1'b1, 8'h04, 3'b000, 3'b000);
    step();
    drive(1'b1, 8'h80, 3'b000, 3'b000);
    step();
    check("rst pre ctrl_q", 32'(bus.ctrl_q), 32'h03_04_80);
    check("rst pre valid_q", 32'(bus.valid_q), 32'h7);
    check("rst pre busy", 32'(bus.mc_busy_o), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("rst async ctrl_q", 32'(bus.ctrl_q), 32'h0);
    check("rst async valid_q", 32'(bus.valid_q), 32'h0);
    check("rst async busy", 32'(bus.mc_busy_o), 32'h0);
    check("rst async stall_d", 32'(bus.stall_d_o), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 8'h05, 3'b000, 3'b000);
    #1;
    check("rst release stall_d", 32'(bus.stall_d_o), 32'h0);
    step();
    check("rst resume stage0", 32'(bus.ctrl_q), 32'h00_00_05);
    check("rst resume valid", 32'(bus.valid_q), 32'h1);
    drive(1'b0, 8'h00, 3'b000, 3'b000);
    step();
    check("rst resume stage1", 32'(bus.ctrl_q), 32'h00_05_00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Parametrised control-signal pipeline carrying a decoded control bundle from decode through N registered stages (default E, M, W). Supports per-stage stall and flush, automatic bubble insertion behind a held stage, per-stage valid bits, and a built-in multi-cycle hold in the first registered stage (EX) for mul/div-class operations. It sits between the main/ALU decoders and the datapath, and replaces the fixed 3-stage control register chain.

## Interface

Parameters:
- `W`, 8: control bundle width in bits.
- `N`, 3: number of registered stages; stage 0 = E, 1 = M, 2 = W.
- `MC_BIT`, 7: bundle bit index marking a multi-cycle operation; 0 ≤ MC_BIT < W.
- `MC_LAT`, 4: total cycles a multi-cycle op occupies stage 0; ≥ 1 (1 = no extra hold).

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `ctrl_d`, in, W: control bundle from decode.
- `valid_d`, in, 1: decode slot holds a real instruction.
- `stall_i`, in, N: external hold request per registered stage.
- `flush_i`, in, N: per-stage flush (kills the stage contents).
- `ctrl_q`, out, N*W: registered bundles; slice [k*W +: W] = stage k.
- `valid_q`, out, N: per-stage valid.
- `stall_d_o`, out, 1: decode must hold its instruction this cycle.
- `mc_busy_o`, out, 1: stage 0 is held by the multi-cycle counter.

## Operation

- Effective hold, combinational: `h[N-1] = stall_i[N-1]`; `h[k] = stall_i[k] | h[k+1]` for k < N-1, with `mc_busy` additionally ORed into `h[0]`. `stall_d_o = h[0]`.
- Per-stage update at each edge, in priority order:
  - flush_i[k]: valid ← 0, ctrl ← 0.
  - h[k]: hold current contents.
  - Upstream held, i.e. k > 0 and h[k-1]: bubble; valid ← 0, ctrl ← 0.
  - Otherwise load from upstream. Stage 0 loads `ctrl_d`/`valid_d`.
- A bubble bundle is all-zero, so every write/enable bit is inactive.
- Multi-cycle counter `cnt` has width clog2(MC_LAT), minimum 1:
  - When stage 0 loads a valid bundle with bit MC_BIT set: cnt ← MC_LAT-1.
  - Else if cnt ≠ 0: cnt ← cnt-1. It decrements even under external stall.
  - flush_i[0]: cnt ← 0. This takes priority over load.
- `mc_busy = valid_q[0] & ctrl_q[0][MC_BIT] & (cnt ≠ 0)`.
- Flushing stage k while stage k-1 is held: stage k is zeroed, and the held stage is unaffected.
- Flush and stall on the same stage: flush wins.

## Timing

- Reset (rst low, asynchronous): ctrl_q = 0, valid_q = 0, cnt = 0. Consequently stall_d_o = 0 and mc_busy_o = 0.
- Latency: a bundle presented on ctrl_d before edge t is visible on stage k after edge t+k, absent stalls.
- stall_d_o and mc_busy_o are combinational from state and stall_i. There is no combinational path from ctrl_d to any output.
- Multi-cycle op, no external stall: it occupies stage 0 for exactly MC_LAT cycles, then advances. mc_busy_o is high for the first MC_LAT-1 of those cycles.
- Reset released mid-hold: state is cleared, and no held op survives.

## Structure

- Package `ctrl_pipe_pkg` holds:
  - Stage index constants: `STG_E = 0`, `STG_M = 1`, `STG_W = 2`.
  - Bundle field positions: memtoreg, memwrite, alusrc, regdst, regwrite, alucontrol[2:0], mc.
  - Default `W`.
- Sub-module `ctrl_stage_reg`: one W-bit + valid register with flush/hold/bubble inputs. It is instantiated N times in a generate loop. The counter and hold chain live in the top module.

## Test plan

- **Straight flow.** valid_d = 1, ctrl_d = 8'h15, no stall. Required: stage0 = 15 after edge 1, stage1 after edge 2, stage2 after edge 3, each with valid = 1.
- **Mid stall.** stall_i = 3'b010 for 2 cycles while stages hold A/B/C. Required: stages 0 and 1 hold A/B; stage 2 receives bubbles (ctrl = 0, valid = 0) for 2 cycles; stall_d_o = 1 during the stall.
- **Flush priority.** flush_i[0] = 1 together with stall_i[0] = 1. Required: stage0 → 0/invalid at the next edge.
- **Multi-cycle op, MC_LAT = 4.** Load ctrl_d = 8'h80. Required: stage 0 holds 80 for 4 cycles; mc_busy_o high for 3 cycles; stage 1 receives 3 bubbles, then 80.
- **Multi-cycle op flushed.** Flush after 1 busy cycle. Required: cnt = 0, mc_busy_o = 0, and the next decode bundle loads at the following edge.
- **Reset mid-operation.** Assert rst low mid-multi-cycle with all stages valid. Required: all outputs 0 immediately without a clock; normal flow resumes after release.
